idct16_odd_mac: RTL and testbench

//  Inverse-transform odd-half engine for the 16-point IDCT in the tq path.

---
 rtl/idct16_odd_mac.sv | 151 +++++++++++++++
 tb/tb_idct16_odd_mac.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct16_odd_mac.sv
// idct16_odd_mac
// Odd-half engine of the 16-point inverse DCT. Takes the 8 odd-row
// coefficients of one column serially, multiplies each beat by its row of the
// constant matrix with shift-add logic, accumulates O[0..7] and presents them
// in parallel to the butterfly stage with a valid/ready handshake.
// Build option: define IDCT16_ODD_SKIP_EN to let i_last end a block early
// (the remaining rows are then treated as zero).

module idct16_odd_mac #(
    parameter  int IN_W  = 16,
    localparam int OUT_W = IN_W + 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_data,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_data_0,
    output logic signed [OUT_W-1:0] o_data_1,
    output logic signed [OUT_W-1:0] o_data_2,
    output logic signed [OUT_W-1:0] o_data_3,
    output logic signed [OUT_W-1:0] o_data_4,
    output logic signed [OUT_W-1:0] o_data_5,
    output logic signed [OUT_W-1:0] o_data_6,
    output logic signed [OUT_W-1:0] o_data_7
);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    // Each matrix entry is one of 8 magnitudes times a sign. A row is packed
    // as eight {neg, mag_idx} nibbles, output j=0 in the top nibble.
    // mag_idx: 0=90 1=87 2=80 3=70 4=57 5=43 6=25 7=9
    function automatic logic [31:0] row_code(input logic [2:0] k);
        logic [31:0] r;
        case (k)
            3'd0:    r = 32'h0123_4567;
            3'd1:    r = 32'h147D_A8BE;
            3'd2:    r = 32'h27B9_E405;
            3'd3:    r = 32'h3D97_06AC;
            3'd4:    r = 32'h4AE0_F953;
            3'd5:    r = 32'h5846_937A;
            3'd6:    r = 32'h6B0A_57C1;
            default: r = 32'h7E5C_3A18;
        endcase
        return r;
    endfunction

    logic [0:0]              r_state;
    logic [2:0]              r_cnt;
    logic signed [OUT_W-1:0] r_acc [8];

    logic signed [OUT_W-1:0] w_x;
    logic signed [OUT_W-1:0] w_p    [8];
    logic signed [OUT_W-1:0] w_term [8];
    logic [31:0]             w_row;
    logic [3:0]              w_code;
    logic                    w_accept;
    logic                    w_end_block;
    logic                    w_last_beat;

`ifdef IDCT16_ODD_SKIP_EN
    assign w_last_beat = i_last;
`else
    // i_last has no meaning when every block is a full 8 beats.
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign w_last_beat   = 1'b0;
`endif

    // Sign-extend the coefficient before shifting so no product can overflow.
    assign w_x = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};

    // Shift-add products of the input with the eight matrix magnitudes.
    always_comb begin
        w_p[0] = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 3) + (w_x <<< 1); // 90
        w_p[1] = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 3) - w_x;         // 87
        w_p[2] = (w_x <<< 6) + (w_x <<< 4);                             // 80
        w_p[3] = (w_x <<< 6) + (w_x <<< 2) + (w_x <<< 1);               // 70
        w_p[4] = (w_x <<< 6) - (w_x <<< 3) + w_x;                       // 57
        w_p[5] = (w_x <<< 5) + (w_x <<< 3) + (w_x <<< 1) + w_x;         // 43
        w_p[6] = (w_x <<< 4) + (w_x <<< 3) + w_x;                       // 25
        w_p[7] = (w_x <<< 3) + w_x;                                     // 9
    end

    // Pick the signed product for each output from the current beat's row.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path leaves it holding its old value (which would be a latch).
        w_row  = row_code(r_cnt);
        w_code = '0;
        for (int j = 0; j < 8; j++) begin
            w_code    = w_row[4*(7-j) +: 4];
            w_term[j] = w_code[3] ? -w_p[w_code[2:0]] : w_p[w_code[2:0]];
        end
    end

    assign w_accept    = i_valid && (r_state == ST_ACC);
    assign w_end_block = (r_cnt == 3'd7) || w_last_beat;

    // Control and accumulator update: accumulate in ACC, hold/release in OUT.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            // NOTE: the accumulator bank is only eight registers and must read
            // zero after reset, so it is reset rather than left uninitialised.
            for (int j = 0; j < 8; j++) r_acc[j] <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        for (int j = 0; j < 8; j++) r_acc[j] <= r_acc[j] + w_term[j];
                        if (w_end_block) begin
                            r_cnt   <= '0;
                            r_state <= ST_OUT;
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_OUT: begin
                    // Results are consumed; clear for the next column. No beat
                    // is taken on this cycle even if i_valid is high.
                    if (i_ready) begin
                        for (int j = 0; j < 8; j++) r_acc[j] <= '0;
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign o_ready  = (r_state == ST_ACC);
    assign o_valid  = (r_state == ST_OUT);
    assign o_data_0 = r_acc[0];
    assign o_data_1 = r_acc[1];
    assign o_data_2 = r_acc[2];
    assign o_data_3 = r_acc[3];
    assign o_data_4 = r_acc[4];
    assign o_data_5 = r_acc[5];
    assign o_data_6 = r_acc[6];
    assign o_data_7 = r_acc[7];

endmodule

// File: tb/tb_idct16_odd_mac.sv
// tb_idct16_odd_mac
// Self-checking bench for idct16_odd_mac: directed vectors plus randomized
// blocks compared against a plain matrix-product reference model.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_idct16_odd_mac;

    localparam int IN_W  = 16;
    localparam int OUT_W = IN_W + 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_valid;
    logic signed [IN_W-1:0]  i_data;
    logic                    i_last;
    logic                    i_ready;
    logic                    o_ready;
    logic                    o_valid;
    logic signed [OUT_W-1:0] o_d [8];

    int checks   = 0;
    int failures = 0;

    longint exp_o [8];

    const int M [8][8] = '{
        '{90,  87,  80,  70,  57,  43,  25,   9},
        '{87,  57,   9, -43, -80, -90, -70, -25},
        '{80,   9, -70, -87, -25,  57,  90,  43},
        '{70, -43, -87,   9,  90,  25, -80, -57},
        '{57, -80, -25,  90,  -9, -87,  43,  70},
        '{43, -90,  57,  25, -87,  70,   9, -80},
        '{25, -70,  90, -80,  43,   9, -57,  87},
        '{ 9, -25,  43, -57,  70, -80,  87, -90}
    };

    always #5 clk = ~clk;

    idct16_odd_mac #(.IN_W(IN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data_0 (o_d[0]),
        .o_data_1 (o_d[1]),
        .o_data_2 (o_d[2]),
        .o_data_3 (o_d[3]),
        .o_data_4 (o_d[4]),
        .o_data_5 (o_d[5]),
        .o_data_6 (o_d[6]),
        .o_data_7 (o_d[7])
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic int rand_coef();
        logic signed [IN_W-1:0] t;
        t = IN_W'($urandom);
        return int'(t);
    endfunction

    // Compare all eight outputs against the model values in exp_o.
    task automatic compare_outputs(input string name);
        logic signed [OUT_W-1:0] e;
        for (int j = 0; j < 8; j++) begin
            e = OUT_W'(exp_o[j]);
            checks++;
            if (o_d[j] !== e) begin
                failures++;
                $display("FAIL %s O[%0d]: got %0d expected %0d", name, j, o_d[j], e);
            end
        end
    endtask

    // Check the idle-after-reset / idle-after-release condition.
    task automatic expect_idle(input string name);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: o_ready=%b o_valid=%b expected 1/0", name, o_ready, o_valid);
        end
        for (int j = 0; j < 8; j++) exp_o[j] = 0;
        compare_outputs({name, "_zero"});
    endtask

    // Send one block; the model is computed here from the matrix definition.
    task automatic send_block(input int x [8], input int last_beat, input bit gaps, input string name);
        int nb;
`ifdef IDCT16_ODD_SKIP_EN
        nb = last_beat + 1;
`else
        nb = 8;
`endif
        for (int j = 0; j < 8; j++) begin
            exp_o[j] = 0;
            for (int k = 0; k < nb; k++) exp_o[j] += longint'(M[k][j]) * longint'(x[k]);
        end
        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                    i_data  = IN_W'($urandom);
                    i_last  = 1'($urandom);
                end
            end
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s beat%0d: o_ready=%b o_valid=%b expected 1/0", name, k, o_ready, o_valid);
            end
            i_valid = 1'b1;
            i_data  = IN_W'(x[k]);
            i_last  = (k == last_beat);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s latency: o_valid=%b o_ready=%b expected 1/0", name, o_valid, o_ready);
        end
        compare_outputs(name);
    endtask

    // Hold results with i_ready low (beats offered and ignored), then release.
    task automatic release_out(input int hold, input string name);
        for (int c = 0; c < hold; c++) begin
            i_ready = 1'b0;
            i_valid = 1'b1;
            i_data  = IN_W'($urandom_range(1, 1000));
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s hold%0d: o_valid=%b o_ready=%b expected 1/0", name, c, o_valid, o_ready);
            end
            compare_outputs({name, "_hold"});
        end
        // Handshake cycle with a nonzero beat offered: it must not be taken.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = IN_W'(5);
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        expect_idle({name, "_release"});
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = IN_W'($urandom);
        i_last  = 1'b1;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        expect_idle("reset");
    endtask

    task automatic test_unit();
        int x [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 7, 1'b0, "unit");
        release_out(0, "unit");
    endtask

    task automatic test_all_ones();
        int x [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_block(x, 7, 1'b0, "ones");
        checks++;
        if (o_d[0] !== 26'sd461 || o_d[1] !== -26'sd155 || o_d[7] !== -26'sd43) begin
            failures++;
            $display("FAIL ones_const: got %0d,%0d,%0d expected 461,-155,-43", o_d[0], o_d[1], o_d[7]);
        end
        release_out(1, "ones");
    endtask

    task automatic test_extremes();
        int xn [8] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        int xp [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        send_block(xn, 7, 1'b0, "min");
        checks++;
        if (o_d[0] !== -26'sd15106048) begin
            failures++;
            $display("FAIL min_O0: got %0d expected -15106048", o_d[0]);
        end
        release_out(0, "min");
        send_block(xp, 7, 1'b1, "max");
        checks++;
        if (o_d[0] !== 26'sd15105587) begin
            failures++;
            $display("FAIL max_O0: got %0d expected 15105587", o_d[0]);
        end
        release_out(0, "max");
    endtask

    task automatic test_back_to_back();
        int xu [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        int xo [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_block(xu, 7, 1'b0, "hold_unit");
        release_out(5, "hold_unit");
        send_block(xo, 7, 1'b0, "after_hold");
        release_out(0, "after_hold");
    endtask

    task automatic test_reset_mid_block();
        int x [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = IN_W'(1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        expect_idle("mid_reset");
        send_block(x, 7, 1'b0, "post_reset");
        release_out(0, "post_reset");
    endtask

    task automatic test_skip();
        int x [8] = '{2, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 0, 1'b1, "skip");
        checks++;
        if (o_d[0] !== 26'sd180 || o_d[7] !== 26'sd18) begin
            failures++;
            $display("FAIL skip_const: got %0d,%0d expected 180,18", o_d[0], o_d[7]);
        end
        release_out(0, "skip");
    endtask

    task automatic test_random();
        int x [8];
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 8; k++) x[k] = rand_coef();
            send_block(x, $urandom_range(0, 7), 1'b1, $sformatf("rand%0d", b));
            release_out($urandom_range(0, 3), $sformatf("rand%0d", b));
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        test_reset();
        test_unit();
        test_all_ones();
        test_extremes();
        test_back_to_back();
        test_reset_mid_block();
        test_skip();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
